// File: rtl/modred_lane_arb.sv
// Round-robin arbiter that shares one fixed-latency modular reduction unit among
// NUM_LANES butterfly lanes, tracking ownership with a tag pipe matched to the unit.
module modred_lane_arb #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 24,
    parameter int RES_W     = 12,
    parameter int PIPE_LAT  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LANES-1:0]          req_valid,
    input  logic [NUM_LANES*DATA_W-1:0]   req_data,
    output logic [NUM_LANES-1:0]          req_ready,
    input  logic [NUM_LANES-1:0]          lane_en,
    input  logic                          pause,
    output logic                          red_in_valid,
    output logic [DATA_W-1:0]             red_in_data,
    input  logic [RES_W-1:0]              red_out_data,
    output logic [NUM_LANES-1:0]          res_valid,
    output logic [RES_W-1:0]              res_data,
    output logic                          busy,
    output logic [15:0]                   op_cnt
);
    localparam int ID_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [DATA_W-1:0]    lane_data [NUM_LANES];
    logic [NUM_LANES-1:0] eligible;
    logic [NUM_LANES-1:0] grant;
    logic                 grant_any;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic                 red_in_valid_q;
    logic [DATA_W-1:0]    red_in_data_q;
    logic [ID_W-1:0]      issue_id_q;
    logic [PIPE_LAT-1:0]  tag_v_q;
    logic [ID_W-1:0]      tag_id_q [PIPE_LAT];
    logic [NUM_LANES-1:0] res_valid_q;
    logic [RES_W-1:0]     res_data_q;
    logic [15:0]          op_cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_data[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Masking is combinational so pause/lane_en/rst act in the same cycle.
    assign eligible = req_valid & lane_en & {NUM_LANES{~pause & ~rst}};

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_LANES;
            if (!grant_any && eligible[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_LANES - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            red_in_valid_q <= 1'b0;
            red_in_data_q  <= '0;
            issue_id_q     <= '0;
            tag_v_q        <= '0;
            res_valid_q    <= '0;
            res_data_q     <= '0;
            op_cnt_q       <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            red_in_valid_q <= grant_any;
            issue_id_q     <= grant_id;
            if (grant_any) begin
                red_in_data_q <= lane_data[grant_id];
            end
            op_cnt_q <= op_cnt_q + 16'(grant_any);

            // Tag head is fed from the issue register so the tail lines up with red_out_data.
            tag_v_q[0]  <= red_in_valid_q;
            tag_id_q[0] <= issue_id_q;
            for (int k = 1; k < PIPE_LAT; k++) begin
                tag_v_q[k]  <= tag_v_q[k-1];
                tag_id_q[k] <= tag_id_q[k-1];
            end

            if (tag_v_q[PIPE_LAT-1]) begin
                res_valid_q <= NUM_LANES'(1) << tag_id_q[PIPE_LAT-1];
                res_data_q  <= red_out_data;
            end else begin
                res_valid_q <= '0;
            end
        end
    end

    assign req_ready    = grant;
    assign red_in_valid = red_in_valid_q;
    assign red_in_data  = red_in_data_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign op_cnt       = op_cnt_q;
    assign busy         = red_in_valid_q | (|tag_v_q) | (|res_valid_q);

endmodule

// File: tb/tb_modred_lane_arb.sv
// Directed bench for modred_lane_arb with a behavioural fixed-latency reduction unit.
module tb_modred_lane_arb;
    localparam int NL = 4;
    localparam int DW = 24;
    localparam int RW = 12;
    localparam int PL = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NL-1:0]    req_valid;
    logic [NL*DW-1:0] req_data;
    logic [NL-1:0]    req_ready;
    logic [NL-1:0]    lane_en;
    logic             pause;
    logic             red_in_valid;
    logic [DW-1:0]    red_in_data;
    logic [RW-1:0]    red_out_data;
    logic [NL-1:0]    res_valid;
    logic [RW-1:0]    res_data;
    logic             busy;
    logic [15:0]      op_cnt;

    modred_lane_arb #(.NUM_LANES(NL), .DATA_W(DW), .RES_W(RW), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .lane_en(lane_en), .pause(pause),
        .red_in_valid(red_in_valid), .red_in_data(red_in_data),
        .red_out_data(red_out_data), .res_valid(res_valid), .res_data(res_data),
        .busy(busy), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] unit_f(input logic [DW-1:0] d);
        return d[11:0] ^ d[23:12] ^ 12'hF19;
    endfunction

    // Reduction unit: result PL cycles after issue, garbage when nothing was issued.
    logic [RW-1:0] unit_pipe [PL];
    always @(posedge clk) begin
        unit_pipe[0] <= red_in_valid ? unit_f(red_in_data) : RW'($urandom);
        for (int k = 1; k < PL; k++) unit_pipe[k] <= unit_pipe[k-1];
    end
    assign red_out_data = unit_pipe[PL-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic [NL-1:0] v;
        logic [RW-1:0] d;
    } res_t;
    res_t resq[$];
    always @(negedge clk) begin
        if (res_valid != '0) begin
            resq.push_back('{c: cyc, v: res_valid, d: res_data});
            $display("[%0d] result lane_mask=%b data=0x%03h", cyc, res_valid, res_data);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_lane(input int lane, input logic [DW-1:0] val);
        req_data[lane*DW +: DW] = val;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1; req_valid = '0; pause = 1'b0; lane_en = '1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] cont_data(input int k, input int lane);
        return DW'(32'h10000 * (k + 1) + 32'h100 * lane + 32'h3C);
    endfunction

    int t0;
    logic [DW-1:0] d6;

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; lane_en = '1; pause = 1'b0;

        // Reset with random inputs
        for (int k = 0; k < 2; k++) begin
            if (k > 0) next_cycle();
            req_valid = NL'($urandom);
            lane_en   = NL'($urandom);
            pause     = 1'($urandom);
            for (int i = 0; i < NL; i++) set_lane(i, DW'($urandom));
            sample();
            check_eq("rst_req_ready", 32'(req_ready), 32'h0);
            check_eq("rst_red_in_valid", 32'(red_in_valid), 32'h0);
            check_eq("rst_res_valid", 32'(res_valid), 32'h0);
            check_eq("rst_busy", 32'(busy), 32'h0);
            check_eq("rst_op_cnt", 32'(op_cnt), 32'h0);
            $display("[%0d] reset cycle %0d", cyc, k);
        end
        next_cycle();
        rst = 1'b0; req_valid = '0; lane_en = '1; pause = 1'b0;
        sample();
        check_eq("rel_req_ready", 32'(req_ready), 32'h0);
        check_eq("rel_red_in_valid", 32'(red_in_valid), 32'h0);
        check_eq("rel_busy", 32'(busy), 32'h0);
        check_eq("rel_op_cnt", 32'(op_cnt), 32'h0);

        // Single request on lane 2
        next_cycle();
        req_valid = 4'b0100; set_lane(2, 24'h000ABC);
        sample();
        check_eq("single_grant", 32'(req_ready), 32'h4);
        $display("[%0d] single request lane 2 ready=%b", cyc, req_ready);
        next_cycle();
        req_valid = '0;
        sample();
        check_eq("single_issue_v", 32'(red_in_valid), 32'h1);
        check_eq("single_issue_d", 32'(red_in_data), 32'h000ABC);
        check_eq("single_op_cnt", 32'(op_cnt), 32'h1);
        for (int d = 2; d <= 6; d++) begin
            next_cycle();
            sample();
            if (d == 5) begin
                check_eq("single_res_valid", 32'(res_valid), 32'h4);
                check_eq("single_res_data", 32'(res_data), 32'h5A5);
            end else begin
                check_eq("single_res_idle", 32'(res_valid), 32'h0);
            end
        end
        check_eq("single_busy_low", 32'(busy), 32'h0);

        // Full contention
        do_reset();
        resq.delete();
        t0 = 0;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            req_valid = '1;
            for (int i = 0; i < NL; i++) set_lane(i, cont_data(k, i));
            sample();
            if (k == 0) t0 = cyc;
            check_eq("cont_grant", 32'(req_ready), 32'(1) << (k % 4));
            $display("[%0d] contention k=%0d ready=%b", cyc, k, req_ready);
        end
        next_cycle();
        req_valid = '0;
        for (int k = 0; k < 8; k++) next_cycle();
        sample();
        check_eq("cont_res_count", 32'(resq.size()), 32'd8);
        check_eq("cont_op_cnt", 32'(op_cnt), 32'd8);
        for (int k = 0; k < 8 && k < resq.size(); k++) begin
            check_eq("cont_res_cyc", 32'(resq[k].c), 32'(t0 + 5 + k));
            check_eq("cont_res_lane", 32'(resq[k].v), 32'(1) << (k % 4));
            check_eq("cont_res_data", 32'(resq[k].d), 32'(unit_f(cont_data(k, k % 4))));
        end

        // Wrap and mask: move pointer to 2, then mask lane 1
        do_reset();
        next_cycle();
        req_valid = 4'b0010;
        sample();
        check_eq("wrap_setup", 32'(req_ready), 32'h2);
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            req_valid = 4'b1011; lane_en = 4'b1101;
            sample();
            check_eq("wrap_grant", 32'(req_ready), (k % 2 == 0) ? 32'h8 : 32'h1);
            $display("[%0d] wrap/mask k=%0d ready=%b", cyc, k, req_ready);
        end
        next_cycle();
        req_valid = '0; lane_en = '1;

        // Pause drain
        do_reset();
        resq.delete();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            req_valid = '1; pause = 1'b0;
            for (int i = 0; i < NL; i++) set_lane(i, cont_data(k + 4, i));
            sample();
            if (k == 0) t0 = cyc;
            check_eq("pause_pre_grant", 32'(req_ready), 32'(1) << k);
        end
        for (int k = 3; k <= 8; k++) begin
            next_cycle();
            pause = 1'b1;
            sample();
            check_eq("pause_ready", 32'(req_ready), 32'h0);
            check_eq("pause_busy", 32'(busy), (k <= 7) ? 32'h1 : 32'h0);
            $display("[%0d] paused k=%0d busy=%b", cyc, k, busy);
        end
        next_cycle();
        pause = 1'b0; req_valid = '0;
        check_eq("pause_res_count", 32'(resq.size()), 32'd3);
        for (int k = 0; k < 3 && k < resq.size(); k++) begin
            check_eq("pause_res_cyc", 32'(resq[k].c), 32'(t0 + 5 + k));
            check_eq("pause_res_lane", 32'(resq[k].v), 32'(1) << k);
        end

        // Reset mid-flight
        do_reset();
        d6 = 24'h123456;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            req_valid = 4'b0011;
            set_lane(0, d6); set_lane(1, 24'h654321);
            sample();
            check_eq("mid_grant", 32'(req_ready), 32'(1) << k);
        end
        next_cycle();
        req_valid = '0;
        sample();
        check_eq("mid_issue", 32'(red_in_valid), 32'h1);
        next_cycle();
        rst = 1'b1; req_valid = '1;
        sample();
        check_eq("mid_rst_ready", 32'(req_ready), 32'h0);
        next_cycle();
        rst = 1'b0;
        sample();
        check_eq("mid_post_grant", 32'(req_ready), 32'h1);
        check_eq("mid_op_cnt", 32'(op_cnt), 32'h0);
        check_eq("mid_res_none", 32'(res_valid), 32'h0);
        $display("[%0d] post-reset ready=%b", cyc, req_ready);
        next_cycle();
        req_valid = '0;
        sample();
        check_eq("mid_op_cnt_1", 32'(op_cnt), 32'h1);
        check_eq("mid_res_none", 32'(res_valid), 32'h0);
        for (int k = 6; k <= 9; k++) begin
            next_cycle();
            sample();
            if (k == 9) begin
                check_eq("mid_new_res", 32'(res_valid), 32'h1);
                check_eq("mid_new_data", 32'(res_data), 32'(unit_f(d6)));
            end else begin
                check_eq("mid_res_none", 32'(res_valid), 32'h0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/modred_lane_arb.md
Name: modred_lane_arb

Overview:
- Round-robin arbiter and sequencer that shares one fixed-latency modular reduction unit among NUM_LANES NTT butterfly lanes.
- The shared unit is a compressor tree followed by a CPA; it has no stall input.
- The block takes product requests over valid/ready and issues at most one product per cycle into the unit.
- It tracks lane ownership through a tag pipeline matched to the unit latency and returns each reduced result to its originating lane.

Parameters:
- NUM_LANES, 4, number of requesting lanes (1..16)
- DATA_W, 24, product width sent to the reduction unit
- RES_W, 12, reduced result width
- PIPE_LAT, 3, cycles from red_in_valid to valid red_out_data (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_LANES  per-lane request valid
- req_data  in  NUM_LANES*DATA_W  per-lane product; lane i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_LANES  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
- lane_en  in  NUM_LANES  lane mask; a disabled lane is never granted
- pause  in  1  when high, no new grants are issued; in-flight operations drain
- red_in_valid  out  1  issue strobe to the reduction unit
- red_in_data  out  DATA_W  operand to the reduction unit
- red_out_data  in  RES_W  reduction unit output, valid exactly PIPE_LAT cycles after issue
- res_valid  out  NUM_LANES  one-hot result strobe
- res_data  out  RES_W  result bus shared by all lanes
- busy  out  1  high while any operation is in flight
- op_cnt  out  16  accepted-operation counter

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: req_ready combinationally 0 while rst=1; red_in_valid=0, red_in_data=0, res_valid=0, res_data=0, busy=0, op_cnt=0, rr_ptr=0, all tag-pipe valids 0.
- Arbitration:
  - Eligible lanes are those with req_valid & lane_en & ~pause & ~rst.
  - The grant goes to the first eligible lane scanning upward from rr_ptr, wrapping modulo NUM_LANES.
  - req_ready is combinational from the current inputs and rr_ptr, and is at most one-hot.
  - Lanes must not make req_valid depend combinationally on req_ready.
  - On a grant to lane g, rr_ptr <= (g+1) mod NUM_LANES. With no grant, rr_ptr holds.
  - NUM_LANES=1: rr_ptr is constantly 0.
- Issue: registered. On a grant in cycle T, red_in_valid=1 and red_in_data=req_data[g] in cycle T+1; otherwise red_in_valid=0 and red_in_data holds its value.
- Tag pipeline:
  - A PIPE_LAT-deep shift register of {valid, lane_id} is loaded alongside red_in_valid.
  - Its output aligns with red_out_data.
- Return: registered. When the tag output is valid, then in the next cycle res_valid = onehot(lane_id) and res_data = red_out_data. Otherwise res_valid=0 and res_data holds.
- Total latency: acceptance at T gives res_valid at T+2+PIPE_LAT. Results return in acceptance order.
- Throughput: one operation per cycle, sustained indefinitely, with back-to-back results.
- Lanes cannot back-pressure results; a lane must sink res_valid in the cycle it is asserted.
- red_out_data is ignored whenever the tag output is invalid.
- busy = red_in_valid | any tag valid | any res_valid bit.
- op_cnt increments by 1 per accepted request and wraps from 0xFFFF to 0.
- pause or lane_en changes take effect in the same cycle (combinational masking). A lane disabled while requesting simply waits and keeps req_valid asserted.
- Starvation bound: a continuously eligible lane is granted within NUM_LANES cycles.
- Reset mid-operation:
  - All in-flight tags are discarded and no res_valid follows.
  - Unit outputs arriving after reset are ignored.
  - Arbitration restarts at lane 0.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> req_ready=0, red_in_valid=0, res_valid=0, busy=0, op_cnt=0 throughout and on the first cycle after release.
- Single request: lane 2, req_data=0x000ABC at T, unit model returns 0x5A5 -> req_ready=4'b0100 at T; red_in_valid with 0x000ABC at T+1; res_valid=4'b0100 with res_data=0x5A5 at T+5; op_cnt=1.
- Full contention: all 4 lanes request every cycle for 8 cycles -> grants 0,1,2,3,0,1,2,3; results appear in the same order on consecutive cycles; op_cnt=8.
- Wrap and mask: rr_ptr=2, lanes 0,1,3 request with lane_en=4'b1101 -> grants 3,0,3,0...; lane 1 is never granted.
- Pause drain: 3 operations in flight, then pause=1 with all lanes requesting -> req_ready=0; 3 results emerge; busy falls the cycle after the last res_valid.
- Reset mid-flight: rst pulsed 1 cycle after 2 issues -> no res_valid afterwards; op_cnt=0; first post-reset grant goes to lane 0.
